// File: rtl/gauss_batch_ctrl_if.sv
// Stream bundle for gauss_batch_ctrl: upstream PRNG words, MKGAUSS issue/return, sample output.
// master = controller side, slave = environment side (PRNG, MKGAUSS, sample consumer).
interface gauss_batch_ctrl_if;
   logic        rng_valid;
   logic        rng_ready;
   logic [63:0] rng_data;
   logic        mkg_in_valid;
   logic [63:0] mkg_rng;
   logic        mkg_out_valid;
   logic [31:0] mkg_val;
   logic        smp_valid;
   logic        smp_ready;
   logic [31:0] smp_data;
   logic        smp_last;

   modport master (
      input  rng_valid, rng_data, mkg_out_valid, mkg_val, smp_ready,
      output rng_ready, mkg_in_valid, mkg_rng, smp_valid, smp_data, smp_last
   );

   modport slave (
      output rng_valid, rng_data, mkg_out_valid, mkg_val, smp_ready,
      input  rng_ready, mkg_in_valid, mkg_rng, smp_valid, smp_data, smp_last
   );
endinterface

// File: rtl/gauss_batch_ctrl.sv
// Sequences MKGAUSS for one batch of 2^logn samples using credit-based issue into a result FIFO.
// Optional macro GAUSS_NORM_EN adds norm_sq, a saturating sum of squared delivered samples.
module gauss_batch_ctrl #(
   parameter int LOGN_MAX   = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  logn,
   output logic        busy,
   output logic        done,
   output logic        err,
`ifdef GAUSS_NORM_EN
   output logic [31:0] norm_sq,
`endif
   gauss_batch_ctrl_if.master bus
);
   localparam int CW = LOGN_MAX + 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int OW = PW + 1;
   localparam int SW = PW + 2;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] n_q, n_d;
   logic [CW-1:0] issued_q, issued_d;
   logic [CW-1:0] delivered_q, delivered_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] fcount_q, fcount_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          err_q, err_d;
   logic          mkg_v_q, mkg_v_d;
   logic [63:0]   mkg_rng_q, mkg_rng_d;
   logic [31:0]   mem [FIFO_DEPTH];

   logic          start_acc, logn_sat, fifo_empty, fifo_full;
   logic          rng_ready_w, fire, pop, ret_live, push, ret_err;
   logic [CW-1:0] n_new;
   logic [SW-1:0] credit_sum;
   logic [31:0]   head;

   // Credit check uses registered counters only, so rng_ready never depends on rng_valid.
   always_comb begin
      logn_sat    = int'(logn) > LOGN_MAX;
      n_new       = logn_sat ? (CW'(1) << LOGN_MAX) : (CW'(1) << logn);
      start_acc   = (state_q == S_IDLE) && start;
      fifo_empty  = (fcount_q == '0);
      fifo_full   = (fcount_q == OW'(FIFO_DEPTH));
      credit_sum  = SW'(outst_q) + SW'(fcount_q);
      rng_ready_w = (state_q == S_RUN) && (issued_q < n_q) &&
                    (credit_sum < SW'(FIFO_DEPTH));
      fire        = bus.rng_valid && rng_ready_w;
      pop         = !fifo_empty && bus.smp_ready;
      ret_live    = bus.mkg_out_valid && (outst_q != '0);
      push        = ret_live && (!fifo_full || pop);
      ret_err     = bus.mkg_out_valid && !push;
      head        = mem[rd_ptr_q];
   end

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      issued_d    = issued_q + CW'(fire);
      delivered_d = delivered_q + CW'(pop);
      outst_d     = outst_q;
      fcount_d    = fcount_q;
      wr_ptr_d    = wr_ptr_q + PW'(push);
      rd_ptr_d    = rd_ptr_q + PW'(pop);
      err_d       = err_q;
      mkg_v_d     = fire;
      mkg_rng_d   = fire ? bus.rng_data : mkg_rng_q;

      if (fire && !ret_live)      outst_d = outst_q + OW'(1);
      else if (!fire && ret_live) outst_d = outst_q - OW'(1);

      if (push && !pop)      fcount_d = fcount_q + OW'(1);
      else if (!push && pop) fcount_d = fcount_q - OW'(1);

      unique case (state_q)
         S_IDLE: begin
            if (start_acc) begin
               state_d     = S_RUN;
               n_d         = n_new;
               issued_d    = '0;
               delivered_d = '0;
               outst_d     = '0;
               err_d       = logn_sat;
            end
         end
         S_RUN:   if (issued_q == n_q) state_d = S_DRAIN;
         S_DRAIN: if (delivered_q == n_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (ret_err) err_d = 1'b1;
   end

   always_comb begin
      busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
      done             = (state_q == S_DONE);
      err              = err_q;
      bus.rng_ready    = rng_ready_w;
      bus.mkg_in_valid = mkg_v_q;
      bus.mkg_rng      = mkg_rng_q;
      bus.smp_valid    = !fifo_empty;
      bus.smp_data     = fifo_empty ? '0 : head;
      bus.smp_last     = !fifo_empty && (delivered_q == n_q - CW'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         issued_q    <= '0;
         delivered_q <= '0;
         outst_q     <= '0;
         fcount_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         err_q       <= 1'b0;
         mkg_v_q     <= 1'b0;
         mkg_rng_q   <= '0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         issued_q    <= issued_d;
         delivered_q <= delivered_d;
         outst_q     <= outst_d;
         fcount_q    <= fcount_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         err_q       <= err_d;
         mkg_v_q     <= mkg_v_d;
         mkg_rng_q   <= mkg_rng_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.mkg_val;
   end

`ifdef GAUSS_NORM_EN
   logic [31:0]        norm_q, norm_d;
   logic signed [63:0] smp_ext, sq;
   logic [64:0]        sum;

   // Square of a 32-bit signed value is below 2^63, so the 65-bit sum cannot wrap.
   always_comb begin
      smp_ext = signed'({{32{head[31]}}, head});
      sq      = smp_ext * smp_ext;
      sum     = {33'b0, norm_q} + {1'b0, sq};
      norm_d  = norm_q;
      if (start_acc)
         norm_d = '0;
      else if (pop)
         norm_d = (sum[64:32] != '0) ? '1 : sum[31:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) norm_q <= '0;
      else        norm_q <= norm_d;
   end

   assign norm_sq = norm_q;
`endif
endmodule

// File: tb/tb_gauss_batch_ctrl.sv
// Bench for gauss_batch_ctrl: table of batch configurations driven by random PRNG/sink agents,
// a latency-queue MKGAUSS model and a scoreboard of expected samples, plus directed corner sequences.
module tb_gauss_batch_ctrl;
   localparam int FD = 8;

   typedef struct {
      logic [3:0]  logn;
      int          lat;
      int          rdy_mode;   // 0 always ready, 1 stalled 30 cycles, 2 random
      int          rv_mode;    // 0 always valid, 1 random
      int          val_mode;   // 0 values 1..n, 1 random, 2 dir_vals
      int          exp_n;
      logic        exp_err;
      int          max_cyc;    // 0 = no throughput bound
      bit          chk_norm;
      logic [31:0] exp_norm;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] v;
   } ret_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start;
   logic [3:0]  logn;
   logic        busy, done, err;
`ifdef GAUSS_NORM_EN
   logic [31:0] norm_sq;
`endif

   gauss_batch_ctrl_if bus();

   gauss_batch_ctrl #(.LOGN_MAX(10), .FIFO_DEPTH(FD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .logn  (logn),
      .busy  (busy),
      .done  (done),
      .err   (err),
`ifdef GAUSS_NORM_EN
      .norm_sq (norm_sq),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   int          cyc = 0, c0 = 0;
   int          lat = 1, rdy_mode = 0, rv_mode = 0, val_mode = 0;
   bit          in_batch = 0, inject = 0;
   int          acc = 0, del = 0, n_exp = 0, n_issue = 0, done_cnt = 0;
   logic [31:0] exp_q[$];
   logic [63:0] iss_q[$];
   ret_t        mq[$];
   logic [31:0] norm_m = '0;
   int          dir_vals[4];
   vec_t        vecs[7];

   task automatic chk1(input string nm, input logic a, input logic e);
      checks++;
      if (a !== e) begin failures++; $display("FAIL %s actual=%0b required=%0b", nm, a, e); end
   endtask
   task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin failures++; $display("FAIL %s actual=%0h required=%0h", nm, a, e); end
   endtask
   task automatic chk64(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin failures++; $display("FAIL %s actual=%0h required=%0h", nm, a, e); end
   endtask
   task automatic chki(input string nm, input int a, input int e);
      checks++;
      if (a != e) begin failures++; $display("FAIL %s actual=%0d required=%0d", nm, a, e); end
   endtask
   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", nm);
   endtask

   function automatic logic [31:0] norm_add(input logic [31:0] a, input logic [31:0] v);
      longint      s;
      logic [63:0] sum;
      s   = longint'(signed'(v));
      sum = 64'(a) + 64'(s * s);
      return (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

   // One clock of all agents, evaluated at the falling edge.
   task automatic tick();
      logic        r, v;
      logic [31:0] lo;
      logic [63:0] w;
      ret_t        m;
      @(negedge clk);
      cyc++;
      chk1("rng_ready", bus.rng_ready,
           in_batch && (acc < n_exp) && ((acc - del) < FD));

      if (bus.mkg_in_valid) begin
         if (iss_q.size() == 0) fail_now("mkg_issue_unexpected");
         else chk64("mkg_rng", bus.mkg_rng, iss_q.pop_front());
         mq.push_back('{due: cyc + lat, v: bus.mkg_rng[31:0]});
         n_issue++;
      end
      if (inject) begin
         bus.mkg_out_valid = 1'b1;
         bus.mkg_val       = 32'd123;
         inject            = 0;
      end else if (mq.size() != 0 && mq[0].due == cyc) begin
         m = mq.pop_front();
         bus.mkg_out_valid = 1'b1;
         bus.mkg_val       = m.v;
      end else begin
         bus.mkg_out_valid = 1'b0;
         bus.mkg_val       = $urandom;
      end

      case (rdy_mode)
         0:       r = 1'b1;
         1:       r = (cyc - c0) >= 30;
         default: r = ($urandom_range(0, 3) != 0);
      endcase
      if (bus.smp_valid) begin
         if (exp_q.size() == 0) fail_now("smp_valid_unexpected");
         else begin
            chk32("smp_data", bus.smp_data, exp_q[0]);
            chk1("smp_last", bus.smp_last, del == n_exp - 1);
            if (r) begin
               norm_m = norm_add(norm_m, exp_q[0]);
               void'(exp_q.pop_front());
               del++;
            end
         end
      end
      bus.smp_ready = r;

      if (done) begin
         done_cnt++;
         chki("delivered_at_done", del, n_exp);
         chk1("busy_in_done", busy, 1'b0);
         in_batch = 0;
      end

      v = (rv_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      case (val_mode)
         0:       lo = 32'(acc + 1);
         1:       lo = $urandom;
         default: lo = 32'(dir_vals[acc % 4]);
      endcase
      w = {32'($urandom), lo};
      if (v && bus.rng_ready) begin
         exp_q.push_back(lo);
         iss_q.push_back(w);
         acc++;
      end
      bus.rng_valid = v;
      bus.rng_data  = w;
   endtask

   task automatic check_reset(input string tag);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk1({tag, "_done"}, done, 1'b0);
      chk1({tag, "_err"}, err, 1'b0);
      chk1({tag, "_rng_ready"}, bus.rng_ready, 1'b0);
      chk1({tag, "_mkg_in_valid"}, bus.mkg_in_valid, 1'b0);
      chk64({tag, "_mkg_rng"}, bus.mkg_rng, 64'd0);
      chk1({tag, "_smp_valid"}, bus.smp_valid, 1'b0);
      chk32({tag, "_smp_data"}, bus.smp_data, 32'd0);
      chk1({tag, "_smp_last"}, bus.smp_last, 1'b0);
`ifdef GAUSS_NORM_EN
      chk32({tag, "_norm_sq"}, norm_sq, 32'd0);
`endif
   endtask

   task automatic begin_batch(input vec_t v);
      lat = v.lat; rdy_mode = v.rdy_mode; rv_mode = v.rv_mode; val_mode = v.val_mode;
      n_exp = v.exp_n; acc = 0; del = 0; n_issue = 0; done_cnt = 0; norm_m = '0;
      exp_q.delete(); iss_q.delete();
      start = 1'b1; logn = v.logn; in_batch = 1; c0 = cyc;
      tick();
      start = 1'b0;
      chk1("busy_after_start", busy, 1'b1);
   endtask

   task automatic run_batch(input vec_t v);
      begin_batch(v);
      while (done_cnt == 0 && (cyc - c0) < 30 * v.exp_n + 300) tick();
      if (done_cnt == 0) fail_now("done_timeout");
      else begin
         if (v.max_cyc != 0) chk1("throughput_bound", (cyc - c0) <= v.max_cyc, 1'b1);
         chk1("err_at_done", err, v.exp_err);
`ifdef GAUSS_NORM_EN
         chk32("norm_sq_model", norm_sq, norm_m);
         if (v.chk_norm) chk32("norm_sq_value", norm_sq, v.exp_norm);
`endif
      end
      repeat (4) tick();
      chki("done_pulses", done_cnt, 1);
      chki("issue_count", n_issue, n_exp);
      chki("delivered_count", del, n_exp);
      chk1("busy_after_done", busy, 1'b0);
      chk1("smp_valid_after_done", bus.smp_valid, 1'b0);
`ifdef GAUSS_NORM_EN
      chk32("norm_sq_hold", norm_sq, norm_m);
`endif
   endtask

   initial begin
      vec_t rv;
      start = 1'b0; logn = '0;
      bus.rng_valid = 1'b0; bus.rng_data = '0; bus.mkg_out_valid = 1'b0;
      bus.mkg_val = '0; bus.smp_ready = 1'b0;
      dir_vals = '{1, 2, 3, 4};
      //          logn lat rdy rv val  n    err  max   norm
      vecs[0] = '{4'd3,  4, 0, 0, 0,    8, 1'b0, 0,    0, 32'd0};
      vecs[1] = '{4'd4,  4, 1, 0, 0,   16, 1'b0, 0,    0, 32'd0};
      vecs[2] = '{4'd12, 3, 0, 0, 1, 1024, 1'b1, 1048, 0, 32'd0};
      vecs[3] = '{4'd0,  1, 2, 1, 1,    1, 1'b0, 0,    0, 32'd0};
      vecs[4] = '{4'd5,  7, 2, 1, 1,   32, 1'b0, 0,    0, 32'd0};
      vecs[5] = '{4'd10, 2, 2, 1, 1, 1024, 1'b0, 0,    0, 32'd0};
      vecs[6] = '{4'd2,  1, 0, 0, 0,    4, 1'b0, 0,    0, 32'd0};

      #1 rst_n = 1'b0;
      #1 check_reset("reset");
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();

      for (int i = 0; i < 7; i++) run_batch(vecs[i]);

      // Stray MKGAUSS result while idle.
      inject = 1;
      tick(); tick();
      chk1("idle_inject_err", err, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("idle_inject_smp_valid", bus.smp_valid, 1'b0);
      end

      // Reset in the middle of a 16-sample batch.
      rv = '{4'd4, 4, 0, 0, 0, 16, 1'b0, 0, 0, 32'd0};
      begin_batch(rv);
      while (acc < 5 && (cyc - c0) < 100) tick();
      chk1("reached_5_issues", acc >= 5, 1'b1);
      rst_n = 1'b0;
      #1 check_reset("mid_reset");
      in_batch = 0; acc = 0; del = 0; n_exp = 0; n_issue = 0;
      exp_q.delete(); iss_q.delete(); mq.delete();
      bus.mkg_out_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      rv = '{4'd1, 4, 0, 0, 1, 2, 1'b0, 0, 0, 32'd0};
      run_batch(rv);

`ifdef GAUSS_NORM_EN
      dir_vals = '{3, -4, 0, -1};
      rv = '{4'd2, 4, 0, 0, 2, 4, 1'b0, 0, 1, 32'd26};
      run_batch(rv);
      dir_vals = '{65536, 65536, 0, 0};
      rv = '{4'd2, 3, 2, 1, 2, 4, 1'b0, 0, 1, 32'hFFFF_FFFF};
      run_batch(rv);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
